useq_divider: RTL and testbench

// - Parametrised, iterative, radix-2 restoring unsigned divider for the ALU arithmetic path.
// - Computes quotient and remainder over WIDTH/STEPS_PER_CYCLE clock cycles, replacing a fully unrolled array.
// - Supports valid/ready handshakes on both the operand and result sides, divide-by-zero flagging and abort.
// - Sits between ALU operand select and writeback; the pipeline stalls on start_ready/result_valid.
//

---
 rtl/useq_divider_pkg.sv | 22 ++
 rtl/useq_divider_step.sv | 26 ++
 rtl/useq_divider.sv | 146 ++++++++++++++
 tb/tb_useq_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/useq_divider_pkg.sv
// Shared ALU arithmetic definitions for the iterative divider.
// Holds the divider state encoding, the divide-by-zero quotient fill bit and
// the parameter legality check used at elaboration.
package useq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Divide-by-zero quotient is all ones; replicate this bit to WIDTH.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

  // WIDTH must be >= 2 and split evenly into STEPS_PER_CYCLE-wide chunks.
  function automatic bit div_cfg_ok(input int unsigned width,
                                    input int unsigned steps);
    return (width >= 2) && (steps >= 1) && (steps <= width) &&
           ((width % steps) == 0);
  endfunction

endpackage

// File: rtl/useq_divider_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in  - partial remainder entering the step (must be < divisor)
//   dvd_bit - next dividend bit, shifted into the remainder LSB
//   divisor - divisor (non-zero)
//   rem_out - partial remainder after the trial subtraction
//   q_bit   - quotient bit produced by this step
module udiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // WIDTH+1-bit trial subtract. Because rem_in < divisor, the shifted value is
  // below 2*divisor, so diff[WIDTH] is set exactly when the subtract borrows.
  assign diff    = {rem_in, dvd_bit} - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = diff[WIDTH] ? {rem_in[WIDTH-2:0], dvd_bit} : diff[WIDTH-1:0];

endmodule

// File: rtl/useq_divider.sv
// Iterative radix-2 restoring unsigned divider with valid/ready handshakes.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   start_valid/start_ready     - operand handshake (ready only in IDLE)
//   dividend, divisor           - operands, sampled on accept
//   abort                       - synchronous cancel back to IDLE
//   result_valid/result_ready   - result handshake (valid only in DONE)
//   quotient, remainder         - result, updated only on entry to DONE
//   div_by_zero                 - accepted divisor was zero
//   busy                        - high in CALC or DONE
module useq_divider
  import useq_divider_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / STEPS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] N_LOAD = CW'(N);

  if (!div_cfg_ok(WIDTH, STEPS_PER_CYCLE)) begin : g_bad_cfg
    $error("useq_divider: WIDTH must be >= 2 and a multiple of STEPS_PER_CYCLE");
  end

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out of MSB, quotient bits into LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0]           rem_chain [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]           dvd_next;

  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    udiv_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[i]),
      .dvd_bit (dvd_q[WIDTH-1-i]),
      .divisor (dvs_q),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bits[STEPS_PER_CYCLE-1-i])
    );
  end

  assign dvd_next = (dvd_q << STEPS_PER_CYCLE) | WIDTH'(q_bits);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (abort) begin
      // Abort outranks every transition, including accept and DONE entry,
      // so a cancelled operation never touches the visible result.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            if (divisor == '0) begin
              state_d     = DONE;
              quotient_d  = {WIDTH{DBZ_QUOTIENT_BIT}};
              remainder_d = dividend;
              dbz_d       = 1'b1;
            end else begin
              state_d = CALC;
              cnt_d   = N_LOAD;
              rem_d   = '0;
              dvd_d   = dividend;
              dvs_d   = divisor;
            end
          end
        end
        CALC: begin
          rem_d = rem_chain[STEPS_PER_CYCLE];
          dvd_d = dvd_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d     = DONE;
            quotient_d  = dvd_next;
            remainder_d = rem_chain[STEPS_PER_CYCLE];
            dbz_d       = 1'b0;
          end
        end
        DONE: begin
          if (result_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == CALC) || (state_q == DONE);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_useq_divider.sv
module tb_useq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 32-bit, one step per cycle instance
  logic        start_valid = 1'b0, start_ready, abort = 1'b0;
  logic        result_valid, result_ready = 1'b0, div_by_zero, busy;
  logic [31:0] dividend = '0, divisor = '0, quotient, remainder;

  // 16-bit, four steps per cycle instance
  logic        start_valid_h = 1'b0, start_ready_h, abort_h = 1'b0;
  logic        result_valid_h, result_ready_h = 1'b0, div_by_zero_h, busy_h;
  logic [15:0] dividend_h = '0, divisor_h = '0, quotient_h, remainder_h;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  useq_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor), .abort(abort),
    .result_valid(result_valid), .result_ready(result_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  useq_divider #(.WIDTH(16), .STEPS_PER_CYCLE(4)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid_h), .start_ready(start_ready_h),
    .dividend(dividend_h), .divisor(divisor_h), .abort(abort_h),
    .result_valid(result_valid_h), .result_ready(result_ready_h),
    .quotient(quotient_h), .remainder(remainder_h), .div_by_zero(div_by_zero_h), .busy(busy_h)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge with the divider idle. Returns the number of
  // edges after the accept edge until result_valid, and whether start_ready
  // was ever high / busy low while waiting.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic consume,
                      output int lat, output logic sr_bad);
    start_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; sr_bad = 1'b0;
    while (!result_valid && lat < 100) begin
      if (start_ready || !busy) sr_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (consume) begin
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, output int lat);
    start_valid_h = 1'b1; dividend_h = a; divisor_h = b;
    @(posedge clk); #1;
    start_valid_h = 1'b0; dividend_h = 16'($urandom); divisor_h = 16'($urandom);
    lat = 0;
    while (!result_valid_h && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    result_ready_h = 1'b1;
    @(posedge clk); #1;
    result_ready_h = 1'b0;
  endtask

  initial begin
    vec_t        vecs [10];
    int          lat;
    logic        sr_bad;
    logic [31:0] hq, hr;
    logic [31:0] ra, rb, eq, er;
    logic [15:0] ha, hb, heq, her;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,        1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,        1'b0};
    vecs[2] = '{32'd5,          32'd9,          32'd0,          32'd5,        1'b0};
    vecs[3] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,     1'b1};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,        1'b0};
    vecs[5] = '{32'd1000,       32'd33,         32'd30,         32'd10,       1'b0};
    vecs[6] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,        1'b0};
    vecs[7] = '{32'd12345678,   32'd12345678,   32'd1,          32'd0,        1'b0};
    vecs[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,        1'b0};
    vecs[9] = '{32'd7,          32'hFFFF_FFFF,  32'd0,          32'd7,        1'b0};

    // Reset state
    #12;
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      op32(vecs[i].a, vecs[i].b, 1'b1, lat, sr_bad);
      chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].z);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 0 : 32);
      chk($sformatf("vec%0d_ready_low_in_calc", i), sr_bad, 1'b0);
      chk($sformatf("vec%0d_idle_after_take", i), start_ready, 1'b1);
    end

    // Abort on the very edge that would enter DONE: previous result stays.
    start_valid = 1'b1; dividend = 32'd1000; divisor = 32'd33;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (31) begin @(posedge clk); #1; end
    chk("late_abort_still_calc", busy & ~result_valid, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("late_abort_valid", result_valid, 1'b0);
    chk("late_abort_ready", start_ready, 1'b1);
    chk("late_abort_quotient", quotient, 32'd0);
    chk("late_abort_remainder", remainder, 32'd7);

    // Abort at CALC cycle 5
    start_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort5_idle", start_ready, 1'b1);
    chk("abort5_busy", busy, 1'b0);
    repeat (40) begin @(posedge clk); #1; end
    chk("abort5_no_result", result_valid, 1'b0);

    // Abort in IDLE together with start_valid: operands not accepted
    start_valid = 1'b1; abort = 1'b1; dividend = 32'd9; divisor = 32'd0;
    @(posedge clk); #1;
    start_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_no_accept", busy, 1'b0);
    chk("idle_abort_dbz", div_by_zero, 1'b0);

    // Async reset at CALC cycle 12
    start_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", start_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    op32(32'd1000, 32'd33, 1'b1, lat, sr_bad);
    chk("after_rst_quotient", quotient, 32'd30);
    chk("after_rst_remainder", remainder, 32'd10);
    chk("after_rst_latency", lat, 32);

    // Hold in DONE for 10 cycles, then release with start_valid also high
    op32(32'd100, 32'd7, 1'b0, lat, sr_bad);
    hq = quotient; hr = remainder;
    chk("hold_entry_quotient", hq, 32'd14);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", c), result_valid, 1'b1);
      chk($sformatf("hold%0d_stable", c), {quotient, remainder}, {32'd14, 32'd2});
    end
    result_ready = 1'b1; start_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("release_valid", result_valid, 1'b0);
    chk("release_ready", start_ready, 1'b1);
    chk("release_no_reaccept", busy, 1'b0);
    start_valid = 1'b0;

    // result_ready and abort together in DONE
    op32(32'd9, 32'd4, 1'b0, lat, sr_bad);
    result_ready = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0; abort = 1'b0;
    chk("rdy_abort_idle", start_ready, 1'b1);
    chk("rdy_abort_quotient", quotient, 32'd2);
    chk("rdy_abort_remainder", remainder, 32'd1);

    // 32-bit random vectors
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 0) rb = 32'd3;
      eq = ra / rb; er = ra % rb;
      op32(ra, rb, 1'b1, lat, sr_bad);
      chk($sformatf("r32_%0d_q a=%0h b=%0h", i, ra, rb), quotient, eq);
      chk($sformatf("r32_%0d_r a=%0h b=%0h", i, ra, rb), remainder, er);
    end

    // 16-bit, 4 steps per cycle
    op16(16'hFFFF, 16'h00FF, lat);
    chk("h_ffff_ff_quotient", quotient_h, 16'h0101);
    chk("h_ffff_ff_remainder", remainder_h, 16'h0000);
    chk("h_ffff_ff_latency", lat, 4);
    chk("h_ffff_ff_dbz", div_by_zero_h, 1'b0);
    for (int i = 0; i < 10000; i++) begin
      ha = 16'($urandom);
      case (i % 4)
        0: hb = 16'($urandom_range(0, 15));
        1: hb = 16'($urandom);
        2: hb = 16'($urandom_range(0, 300));
        default: hb = ha + 16'($urandom_range(0, 2));
      endcase
      if (hb == 0) begin heq = 16'hFFFF; her = ha; end
      else begin heq = ha / hb; her = ha % hb; end
      op16(ha, hb, lat);
      chk($sformatf("r16_%0d_q a=%0h b=%0h", i, ha, hb), quotient_h, heq);
      chk($sformatf("r16_%0d_r a=%0h b=%0h", i, ha, hb), remainder_h, her);
      chk($sformatf("r16_%0d_dbz", i), div_by_zero_h, (hb == 0));
      chk($sformatf("r16_%0d_lat", i), lat, (hb == 0) ? 0 : 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
